fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 16, instruction/UART word width.
REQ-002 SHALL have parameter ADDR_W, default 8, instruction-memory word-address width (PC width = ADDR_W).
REQ-003 SHALL have parameter RESET_PC, default 0, first fetch address after entering RUN.
REQ-004 SHALL have parameter BUF_DEPTH, default 2, output-buffer entries (>=2, power of 2).
REQ-005 SHALL use one clock; reset is asynchronous and active-low: clk in 1, rising-edge clock; reset_n in 1, async active-low reset.
REQ-006 SHALL have ports:
- load_mode in 1: request UART program-load mode.
- run_en in 1: permit fetching.
- uart_data in DATA_W: received word.
- uart_valid in 1: uart_data valid.
- uart_ready out 1: word accepted.
- imem_addr out ADDR_W: memory address.
- imem_rd_en out 1: read strobe.
- imem_rdata in DATA_W: read data, 1-cycle latency.
- imem_wr_en out 1: write strobe.
- imem_wdata out DATA_W: write data.
- br_taken in 1: redirect request.
- br_target in ADDR_W: redirect address.
- o_inst out DATA_W: instruction to decode.
- o_pc out ADDR_W: its address.
- o_pc_next out ADDR_W: o_pc+1 mod 2^ADDR_W.
- o_valid out 1: o_inst valid.
- i_ready in 1: decode accepts.
- load_count out ADDR_W+1: words loaded.
- load_ovf out 1: sticky load wrap flag.
- state_o out 2: current state.

Function
REQ-007 SHALL implement states IDLE=0, LOAD=1, RUN=2.
REQ-008 Transitions SHALL be: IDLE->LOAD if load_mode; IDLE->RUN if !load_mode && run_en; LOAD->IDLE if !load_mode; RUN->LOAD if load_mode; RUN->IDLE if !run_en. load_mode has priority.
REQ-009 Every exit from RUN SHALL flush the buffer, kill any in-flight read, and reset PC to RESET_PC.
REQ-010 Entry to LOAD from IDLE or RUN SHALL clear load_count, the load address and load_ovf.
REQ-011 In LOAD, uart_ready SHALL be 1; each uart_valid cycle SHALL drive imem_wr_en=1, imem_addr=load address, imem_wdata=uart_data, then increment the load address and load_count.
REQ-012 The load address SHALL wrap 2^ADDR_W-1 -> 0; a write at the wrap SHALL set load_ovf until the next LOAD entry. load_count SHALL saturate at 2^ADDR_W.
REQ-013 Outside LOAD, uart_ready and imem_wr_en SHALL be 0; UART words are dropped.
REQ-014 In RUN, imem_rd_en SHALL be 1 when entries + in-flight reads < BUF_DEPTH. Each issue SHALL increment PC mod 2^ADDR_W.
REQ-015 Read data SHALL be written to the buffer one cycle after issue. o_valid SHALL rise the cycle after that. Fetch latency is 2 cycles.
REQ-016 The buffer SHALL transfer an entry when o_valid && i_ready. At full throughput, one instruction per cycle SHALL be delivered when i_ready is held 1.
REQ-017 o_inst, o_pc and o_pc_next SHALL stay stable while o_valid && !i_ready.
REQ-018 br_taken in RUN SHALL, in the same cycle:
- flush the buffer;
- kill the in-flight read;
- issue a read at br_target (imem_addr = br_target combinationally);
- set PC to br_target+1.
The target instruction SHALL reach o_valid 2 cycles later.
REQ-019 A transfer (o_valid && i_ready) in the same cycle as br_taken SHALL still count as consumed; redirect wins for all other buffer content.
REQ-020 br_taken outside RUN SHALL be ignored.
REQ-021 o_pc wrap SHALL give o_pc_next=0 when o_pc=2^ADDR_W-1.

Reset
REQ-022 reset_n low SHALL immediately force:
- state IDLE;
- PC=RESET_PC;
- buffer empty, no in-flight read;
- o_valid=0, uart_ready=0, imem_rd_en=0, imem_wr_en=0;
- imem_addr=0, imem_wdata=0;
- o_inst=0, o_pc=0, o_pc_next=0;
- load_count=0, load_ovf=0.
REQ-023 Reset asserted mid-LOAD or mid-RUN SHALL abandon the operation with no memory write in the reset cycle.

Structure
REQ-024 Package fetch_pkg SHALL hold the state encoding constants and the parameter defaults.
REQ-025 The output buffer SHALL be sub-module fetch_buf: a BUF_DEPTH-entry FIFO of {inst, pc} with flush, count and valid/ready interface.

Verification
REQ-026 LOAD: load_mode=1, send 0x1111, 0x2222, 0x3333 -> writes at addresses 0, 1, 2; load_count=3; load_ovf=0.
REQ-027 Wrap: ADDR_W=2, send 5 words -> 5th write at addr 0, load_ovf=1, load_count=4.
REQ-028 RUN streaming: i_ready=1 -> first o_valid 2 cycles after issue, then o_pc 0, 1, 2... one per cycle, matching loaded words.
REQ-029 Backpressure: i_ready=0 for 5 cycles -> o_inst/o_pc held; no drop or duplicate; imem_rd_en stops when buffer + in-flight reads = BUF_DEPTH.
REQ-030 Redirect: br_taken with br_target=0x40 while buffer is full -> flushed; next o_valid shows o_pc=0x40 two cycles later; stale instructions never appear.
REQ-031 Reset during RUN with o_valid=1 -> all outputs at reset values immediately; after release, state=IDLE.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit: state encoding and
// parameter defaults used by fetch_unit and fetch_buf.
package fetch_pkg;

   localparam int unsigned DATA_W_DEF    = 16;
   localparam int unsigned ADDR_W_DEF    = 8;
   localparam int unsigned RESET_PC_DEF  = 0;
   localparam int unsigned BUF_DEPTH_DEF = 2;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_RUN  = 2'd2
   } fetch_state_e;

endpackage

// File: rtl/fetch_buf.sv
// Output buffer of the fetch unit: DEPTH-entry FIFO of {inst, pc}.
// Ports:
//   clk_i, rst_ni            clock, async active-low reset
//   flush_i                  drop all entries (push in the same cycle ignored)
//   push_i, push_*_i         write one entry
//   valid_o, ready_i         head valid / consumer accepts (pop on both)
//   inst_o, pc_o             head entry, zero while empty
//   count_o                  current number of entries
module fetch_buf
   import fetch_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned ADDR_W = ADDR_W_DEF,
   parameter int unsigned DEPTH  = BUF_DEPTH_DEF
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     flush_i,
   input  logic                     push_i,
   input  logic [DATA_W-1:0]        push_inst_i,
   input  logic [ADDR_W-1:0]        push_pc_i,
   output logic                     valid_o,
   input  logic                     ready_i,
   output logic [DATA_W-1:0]        inst_o,
   output logic [ADDR_W-1:0]        pc_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [DATA_W-1:0] inst_q [DEPTH];
   logic [ADDR_W-1:0] pc_q   [DEPTH];
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              pop;
   logic              push_ok;

   assign valid_o = (count_q != '0);
   assign pop     = valid_o && ready_i;
   assign push_ok = push_i && !flush_i;
   assign count_o = count_q;
   assign inst_o  = valid_o ? inst_q[rd_ptr_q] : '0;
   assign pc_o    = valid_o ? pc_q[rd_ptr_q]   : '0;

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (pop)     rd_ptr_d = rd_ptr_q + PTR_W'(1);
         count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: outputs are gated by valid_o.
   always_ff @(posedge clk_i) begin
      if (push_ok) begin
         inst_q[wr_ptr_q] <= push_inst_i;
         pc_q[wr_ptr_q]   <= push_pc_i;
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit with UART program-load mode.
// IDLE: nothing happens. LOAD: each valid UART word is written to
// instruction memory at an auto-incrementing address. RUN: sequential
// fetch into a small output buffer with branch redirect.
// Ports:
//   clk, reset_n                         clock, async active-low reset
//   load_mode, run_en                    mode requests
//   uart_data/uart_valid/uart_ready      program-load word stream
//   imem_addr/rd_en/rdata/wr_en/wdata    instruction memory (1-cycle read)
//   br_taken, br_target                  redirect request
//   o_inst/o_pc/o_pc_next/o_valid/i_ready  decode interface
//   load_count, load_ovf, state_o        status
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int unsigned DATA_W    = DATA_W_DEF,
   parameter int unsigned ADDR_W    = ADDR_W_DEF,
   parameter int unsigned RESET_PC  = RESET_PC_DEF,
   parameter int unsigned BUF_DEPTH = BUF_DEPTH_DEF
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              load_mode,
   input  logic              run_en,
   input  logic [DATA_W-1:0] uart_data,
   input  logic              uart_valid,
   output logic              uart_ready,
   output logic [ADDR_W-1:0] imem_addr,
   output logic              imem_rd_en,
   input  logic [DATA_W-1:0] imem_rdata,
   output logic              imem_wr_en,
   output logic [DATA_W-1:0] imem_wdata,
   input  logic              br_taken,
   input  logic [ADDR_W-1:0] br_target,
   output logic [DATA_W-1:0] o_inst,
   output logic [ADDR_W-1:0] o_pc,
   output logic [ADDR_W-1:0] o_pc_next,
   output logic              o_valid,
   input  logic              i_ready,
   output logic [ADDR_W:0]   load_count,
   output logic              load_ovf,
   output logic [1:0]        state_o
);

   localparam int unsigned     CNT_W   = $clog2(BUF_DEPTH) + 1;
   localparam logic [ADDR_W-1:0] PC_RST  = ADDR_W'(RESET_PC);
   localparam logic [ADDR_W:0]   CNT_MAX = {1'b1, {ADDR_W{1'b0}}};

   fetch_state_e      state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] ld_addr_q, ld_addr_d;
   logic [ADDR_W:0]   ld_cnt_q, ld_cnt_d;
   logic              ovf_q, ovf_d;
   logic              infl_q, infl_d;
   logic [ADDR_W-1:0] infl_pc_q, infl_pc_d;

   logic              in_run, in_load, leave_run, redirect, flush;
   logic              issue, wr, pop, push;
   logic [ADDR_W-1:0] rd_addr;
   logic [CNT_W:0]    occ;
   logic              buf_valid;
   logic [CNT_W-1:0]  buf_count;
   logic [DATA_W-1:0] buf_inst;
   logic [ADDR_W-1:0] buf_pc;

   assign in_run    = (state_q == ST_RUN);
   assign in_load   = (state_q == ST_LOAD);
   assign leave_run = in_run && (load_mode || !run_en);
   assign redirect  = in_run && !leave_run && br_taken;
   assign flush     = leave_run || redirect;
   assign pop       = buf_valid && i_ready;
   assign push      = infl_q && !flush;

   // Occupancy counts the entry leaving this cycle as already gone, so a
   // BUF_DEPTH=2 buffer can still sustain one instruction per cycle.
   assign occ     = {1'b0, buf_count} + (CNT_W+1)'(infl_q) - (CNT_W+1)'(pop);
   assign rd_addr = redirect ? br_target : pc_q;
   assign issue   = in_run && !leave_run &&
                    (redirect || (occ < (CNT_W+1)'(BUF_DEPTH)));
   assign wr      = in_load && uart_valid;

   assign uart_ready = in_load;
   assign imem_wr_en = wr;
   assign imem_rd_en = issue;
   assign imem_wdata = wr ? uart_data : '0;
   always_comb begin
      imem_addr = '0;
      if (wr)         imem_addr = ld_addr_q;
      else if (issue) imem_addr = rd_addr;
   end

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      ld_addr_d = ld_addr_q;
      ld_cnt_d  = ld_cnt_q;
      ovf_d     = ovf_q;
      infl_d    = issue;
      infl_pc_d = rd_addr;

      unique case (state_q)
         ST_IDLE: if (load_mode) state_d = ST_LOAD;
                  else if (run_en) state_d = ST_RUN;
         ST_LOAD: if (!load_mode) state_d = ST_IDLE;
         ST_RUN:  if (load_mode) state_d = ST_LOAD;
                  else if (!run_en) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      if (leave_run)  pc_d = PC_RST;
      else if (issue) pc_d = rd_addr + ADDR_W'(1);

      if (state_d == ST_LOAD && state_q != ST_LOAD) begin
         ld_addr_d = '0;
         ld_cnt_d  = '0;
         ovf_d     = 1'b0;
      end else if (wr) begin
         ld_addr_d = ld_addr_q + ADDR_W'(1);
         // A write after the count saturated landed on a wrapped address.
         if (ld_cnt_q == CNT_MAX) ovf_d = 1'b1;
         else                     ld_cnt_d = ld_cnt_q + (ADDR_W+1)'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= ST_IDLE;
         pc_q      <= PC_RST;
         ld_addr_q <= '0;
         ld_cnt_q  <= '0;
         ovf_q     <= 1'b0;
         infl_q    <= 1'b0;
         infl_pc_q <= '0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         ld_addr_q <= ld_addr_d;
         ld_cnt_q  <= ld_cnt_d;
         ovf_q     <= ovf_d;
         infl_q    <= infl_d;
         infl_pc_q <= infl_pc_d;
      end
   end

   fetch_buf #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .DEPTH  (BUF_DEPTH)
   ) u_buf (
      .clk_i       (clk),
      .rst_ni      (reset_n),
      .flush_i     (flush),
      .push_i      (push),
      .push_inst_i (imem_rdata),
      .push_pc_i   (infl_pc_q),
      .valid_o     (buf_valid),
      .ready_i     (i_ready),
      .inst_o      (buf_inst),
      .pc_o        (buf_pc),
      .count_o     (buf_count)
   );

   assign o_valid    = buf_valid;
   assign o_inst     = buf_inst;
   assign o_pc       = buf_pc;
   assign o_pc_next  = buf_valid ? buf_pc + ADDR_W'(1) : '0;
   assign load_count = ld_cnt_q;
   assign load_ovf   = ovf_q;
   assign state_o    = state_q;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

   localparam int DEPTH = 2;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        load_mode, run_en, uart_valid, br_taken, i_ready;
   logic [15:0] uart_data;
   logic [7:0]  br_target;
   logic        uart_ready, imem_rd_en, imem_wr_en, o_valid, load_ovf;
   logic [7:0]  imem_addr, o_pc, o_pc_next;
   logic [15:0] imem_rdata, imem_wdata, o_inst;
   logic [8:0]  load_count;
   logic [1:0]  state_o;

   // Small instance for address-wrap behaviour
   logic        load_mode_w, uart_valid_w, uart_ready_w, rd_en_w, wr_en_w;
   logic        o_valid_w, load_ovf_w;
   logic [15:0] uart_data_w, wdata_w, o_inst_w;
   logic [15:0] rdata_w = 16'h0;
   logic [1:0]  addr_w, o_pc_w, o_pc_next_w, state_w;
   logic [1:0]  br_target_w = 2'd0;
   logic [2:0]  load_count_w;
   logic        run_en_w = 1'b0, br_taken_w = 1'b0, i_ready_w = 1'b0;

   int nvec = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   fetch_unit #(.DATA_W(16), .ADDR_W(8), .RESET_PC(0), .BUF_DEPTH(DEPTH)) dut (
      .clk(clk), .reset_n(reset_n), .load_mode(load_mode), .run_en(run_en),
      .uart_data(uart_data), .uart_valid(uart_valid), .uart_ready(uart_ready),
      .imem_addr(imem_addr), .imem_rd_en(imem_rd_en), .imem_rdata(imem_rdata),
      .imem_wr_en(imem_wr_en), .imem_wdata(imem_wdata), .br_taken(br_taken),
      .br_target(br_target), .o_inst(o_inst), .o_pc(o_pc), .o_pc_next(o_pc_next),
      .o_valid(o_valid), .i_ready(i_ready), .load_count(load_count),
      .load_ovf(load_ovf), .state_o(state_o));

   fetch_unit #(.DATA_W(16), .ADDR_W(2), .RESET_PC(0), .BUF_DEPTH(2)) dut_w (
      .clk(clk), .reset_n(reset_n), .load_mode(load_mode_w), .run_en(run_en_w),
      .uart_data(uart_data_w), .uart_valid(uart_valid_w), .uart_ready(uart_ready_w),
      .imem_addr(addr_w), .imem_rd_en(rd_en_w), .imem_rdata(rdata_w),
      .imem_wr_en(wr_en_w), .imem_wdata(wdata_w), .br_taken(br_taken_w),
      .br_target(br_target_w), .o_inst(o_inst_w), .o_pc(o_pc_w), .o_pc_next(o_pc_next_w),
      .o_valid(o_valid_w), .i_ready(i_ready_w), .load_count(load_count_w),
      .load_ovf(load_ovf_w), .state_o(state_w));

   // Instruction memories: 1-cycle read latency, write log
   logic [15:0] mem [256];
   logic [7:0]  wlog [$];
   logic [1:0]  wlog_w [$];

   initial for (int i = 0; i < 256; i++) mem[i] = 16'hA000 | 16'(i);

   always @(posedge clk) begin
      if (imem_wr_en) begin
         mem[imem_addr] <= imem_wdata;
         wlog.push_back(imem_addr);
      end
      if (imem_rd_en) imem_rdata <= mem[imem_addr];
      if (wr_en_w) wlog_w.push_back(addr_w);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model + per-cycle compare ----------------
   // Every accepted fetch becomes visible exactly two cycles after its issue,
   // in issue order; the queue holds fetches issued but not yet consumed.
   typedef struct packed {
      logic [7:0] pc;
      int         vis;
   } fetch_t;

   fetch_t     mq [$];
   int         ncyc = 0;
   int         m_state = 0;
   logic [7:0] m_pc = 8'd0;
   logic [7:0] m_ld = 8'd0;
   int         m_cnt = 0;
   logic       exp_valid, pop, we, leaving, redir, re;
   logic [7:0] npc;
   int         nxt;

   always @(negedge clk) begin
      ncyc++;
      if (!reset_n) begin
         chk("rst_state", 32'(state_o), 0);
         chk("rst_o_valid", 32'(o_valid), 0);
         chk("rst_rd_en", 32'(imem_rd_en), 0);
         chk("rst_wr_en", 32'(imem_wr_en), 0);
         chk("rst_uart_ready", 32'(uart_ready), 0);
         chk("rst_addr", 32'(imem_addr), 0);
         chk("rst_wdata", 32'(imem_wdata), 0);
         chk("rst_o_inst", 32'(o_inst), 0);
         chk("rst_o_pc", 32'(o_pc), 0);
         chk("rst_o_pc_next", 32'(o_pc_next), 0);
         chk("rst_load_count", 32'(load_count), 0);
         chk("rst_load_ovf", 32'(load_ovf), 0);
         m_state = 0; mq.delete(); m_pc = 8'd0; m_ld = 8'd0; m_cnt = 0;
      end else begin
         exp_valid = (mq.size() > 0) && (mq[0].vis <= ncyc);
         chk("o_valid", 32'(o_valid), 32'(exp_valid));
         if (exp_valid) begin
            npc = mq[0].pc + 8'd1;
            chk("o_pc", 32'(o_pc), 32'(mq[0].pc));
            chk("o_inst", 32'(o_inst), 32'(mem[mq[0].pc]));
            chk("o_pc_next", 32'(o_pc_next), 32'(npc));
         end
         pop = exp_valid && i_ready;
         chk("state", 32'(state_o), m_state);
         chk("uart_ready", 32'(uart_ready), 32'(m_state == 1));
         we = (m_state == 1) && uart_valid;
         chk("wr_en", 32'(imem_wr_en), 32'(we));
         if (we) begin
            chk("wr_addr", 32'(imem_addr), 32'(m_ld));
            chk("wr_data", 32'(imem_wdata), 32'(uart_data));
         end
         leaving = (m_state == 2) && (load_mode || !run_en);
         redir   = (m_state == 2) && !leaving && br_taken;
         re      = (m_state == 2) && !leaving &&
                   (redir || (mq.size() - int'(pop) < DEPTH));
         chk("rd_en", 32'(imem_rd_en), 32'(re));
         if (re) chk("rd_addr", 32'(imem_addr), 32'(redir ? br_target : m_pc));
         chk("load_count", 32'(load_count), m_cnt);

         if (m_state == 2) begin
            if (leaving) begin
               mq.delete();
               m_pc = 8'd0;
            end else begin
               if (pop) void'(mq.pop_front());
               if (redir) begin
                  mq.delete();
                  mq.push_back('{pc: br_target, vis: ncyc + 2});
                  m_pc = br_target + 8'd1;
               end else if (re) begin
                  mq.push_back('{pc: m_pc, vis: ncyc + 2});
                  m_pc = m_pc + 8'd1;
               end
            end
         end
         if (we) begin
            m_ld = m_ld + 8'd1;
            if (m_cnt < 256) m_cnt++;
         end
         nxt = m_state;
         case (m_state)
            0: if (load_mode) nxt = 1; else if (run_en) nxt = 2;
            1: if (!load_mode) nxt = 0;
            default: if (load_mode) nxt = 1; else if (!run_en) nxt = 0;
         endcase
         if (nxt == 1 && m_state != 1) begin
            m_ld = 8'd0;
            m_cnt = 0;
         end
         m_state = nxt;
      end
   end

   // ---------------- directed stimulus with literal expectations ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [7:0]  held_pc;
   logic [15:0] held_inst;

   initial begin
      reset_n = 1'b1;
      load_mode = 0; run_en = 0; uart_valid = 0; uart_data = '0;
      br_taken = 0; br_target = '0; i_ready = 0;
      load_mode_w = 0; uart_valid_w = 0; uart_data_w = '0;
      #1 reset_n = 1'b0;
      repeat (3) tick();
      chk("d_rst_valid", 32'(o_valid), 0);
      chk("d_rst_state", 32'(state_o), 0);
      reset_n = 1'b1;
      tick();

      // Load-address wrap on the 2-bit instance
      load_mode_w = 1;
      tick();
      uart_valid_w = 1;
      for (int k = 0; k < 5; k++) begin
         uart_data_w = 16'h0100 + 16'(k);
         tick();
      end
      uart_valid_w = 0;
      tick();
      chk("w_nwrites", 32'(wlog_w.size()), 5);
      if (wlog_w.size() == 5) begin
         chk("w_addr0", 32'(wlog_w[0]), 0);
         chk("w_addr3", 32'(wlog_w[3]), 3);
         chk("w_addr4", 32'(wlog_w[4]), 0);
      end
      chk("w_load_count", 32'(load_count_w), 4);
      chk("w_load_ovf", 32'(load_ovf_w), 1);
      load_mode_w = 0;

      // Program load of three words
      load_mode = 1;
      tick();
      uart_valid = 1;
      uart_data = 16'h1111; tick();
      uart_data = 16'h2222; tick();
      uart_data = 16'h3333; tick();
      uart_valid = 0;
      tick();
      chk("ld_nwrites", 32'(wlog.size()), 3);
      if (wlog.size() == 3) begin
         chk("ld_addr0", 32'(wlog[0]), 0);
         chk("ld_addr1", 32'(wlog[1]), 1);
         chk("ld_addr2", 32'(wlog[2]), 2);
      end
      chk("ld_mem1", 32'(mem[1]), 32'h2222);
      chk("ld_count", 32'(load_count), 3);
      chk("ld_ovf", 32'(load_ovf), 0);
      load_mode = 0;
      tick();

      // Streaming from RESET_PC
      run_en = 1; i_ready = 1;
      tick();
      chk("st_state", 32'(state_o), 2);
      chk("st_first_rd", 32'(imem_rd_en), 1);
      chk("st_v0", 32'(o_valid), 0);
      tick();
      chk("st_v1", 32'(o_valid), 0);
      tick();
      chk("st_v2", 32'(o_valid), 1);
      chk("st_pc0", 32'(o_pc), 0);
      chk("st_inst0", 32'(o_inst), 32'h1111);
      tick();
      chk("st_inst1", 32'(o_inst), 32'h2222);
      tick();
      chk("st_inst2", 32'(o_inst), 32'h3333);
      for (int k = 3; k < 8; k++) begin
         tick();
         chk("st_pc", 32'(o_pc), k);
         chk("st_valid", 32'(o_valid), 1);
      end
      chk("st_inst7", 32'(o_inst), 32'hA007);

      // Backpressure for five cycles
      i_ready = 0;
      held_pc = o_pc; held_inst = o_inst;
      for (int k = 0; k < 5; k++) begin
         tick();
         chk("bp_pc", 32'(o_pc), 32'(held_pc));
         chk("bp_inst", 32'(o_inst), 32'(held_inst));
         chk("bp_valid", 32'(o_valid), 1);
      end
      chk("bp_rd_stop", 32'(imem_rd_en), 0);
      i_ready = 1;
      tick();
      chk("bp_next", 32'(o_pc), 32'(held_pc) + 1);
      tick();
      chk("bp_next2", 32'(o_pc), 32'(held_pc) + 2);

      // Redirect with a full buffer
      i_ready = 0;
      repeat (3) tick();
      chk("br_full", 32'(imem_rd_en), 0);
      br_taken = 1; br_target = 8'h40;
      #1;
      chk("br_addr", 32'(imem_addr), 32'h40);
      chk("br_rd", 32'(imem_rd_en), 1);
      tick();
      br_taken = 0;
      chk("br_flushed", 32'(o_valid), 0);
      tick();
      chk("br_valid", 32'(o_valid), 1);
      chk("br_pc", 32'(o_pc), 32'h40);
      chk("br_inst", 32'(o_inst), 32'hA040);
      i_ready = 1;
      tick();
      chk("br_pc41", 32'(o_pc), 32'h41);

      // Redirect coinciding with a transfer, then PC wrap
      br_taken = 1; br_target = 8'hFE;
      tick();
      br_taken = 0;
      chk("br2_flushed", 32'(o_valid), 0);
      tick();
      chk("br2_pc", 32'(o_pc), 32'hFE);
      tick();
      chk("wrap_pc", 32'(o_pc), 32'hFF);
      chk("wrap_next", 32'(o_pc_next), 0);
      tick();
      chk("wrap_pc0", 32'(o_pc), 0);
      chk("wrap_inst0", 32'(o_inst), 32'h1111);

      // Asynchronous reset while delivering
      chk("rr_pre_valid", 32'(o_valid), 1);
      reset_n = 0; run_en = 0;
      #1;
      chk("rr_valid", 32'(o_valid), 0);
      chk("rr_rd", 32'(imem_rd_en), 0);
      chk("rr_inst", 32'(o_inst), 0);
      chk("rr_pc", 32'(o_pc), 0);
      chk("rr_state", 32'(state_o), 0);
      repeat (2) tick();
      reset_n = 1;
      #1;
      chk("rr_rel_state", 32'(state_o), 0);
      tick();
      chk("rr_idle", 32'(state_o), 0);

      // RUN -> IDLE exit flushes
      run_en = 1;
      repeat (4) tick();
      run_en = 0;
      tick();
      chk("ex_state", 32'(state_o), 0);
      chk("ex_valid", 32'(o_valid), 0);

      // Branch and UART traffic outside their states are ignored
      br_taken = 1; br_target = 8'h10; uart_valid = 1; uart_data = 16'hDEAD;
      #1;
      chk("ig_rd", 32'(imem_rd_en), 0);
      chk("ig_wr", 32'(imem_wr_en), 0);
      tick();
      br_taken = 0; uart_valid = 0;
      chk("ig_state", 32'(state_o), 0);
      chk("ig_nwrites", 32'(wlog.size()), 3);

      // RUN -> LOAD clears load status
      run_en = 1;
      repeat (3) tick();
      load_mode = 1;
      tick();
      chk("rl_state", 32'(state_o), 1);
      chk("rl_count", 32'(load_count), 0);
      chk("rl_valid", 32'(o_valid), 0);
      uart_valid = 1; uart_data = 16'h5555;
      tick();
      uart_valid = 0;
      chk("rl_count1", 32'(load_count), 1);
      chk("rl_mem0", 32'(mem[0]), 32'h5555);

      // Reset during LOAD: no write in the reset cycle
      uart_valid = 1; uart_data = 16'h7777;
      #1;
      chk("rw_pre_wr", 32'(imem_wr_en), 1);
      reset_n = 0;
      #1;
      chk("rw_wr", 32'(imem_wr_en), 0);
      chk("rw_addr", 32'(imem_addr), 0);
      chk("rw_wdata", 32'(imem_wdata), 0);
      tick();
      chk("rw_nwrites", 32'(wlog.size()), 4);
      load_mode = 0; uart_valid = 0; run_en = 0;
      reset_n = 1;
      repeat (2) tick();

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
